// File: rtl/pwm_deadtime_guard.sv
// Complementary high/low-side PWM drive with programmable dead band and a latched fault shutdown.
// Define PWM_GUARD_IRQ_EN to drive irq_o from the fault latch and keep an 8-bit fault counter.

module pwm_deadtime_chan #(
   parameter int DT_W = 8
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            pwm_i,
   input  logic            en_i,
   input  logic [DT_W-1:0] dead_time_i,
   input  logic            fault_i,
   output logic            h_o,
   output logic            l_o
);
   typedef enum logic [1:0] {IDLE, HIGH, LOW, DEAD} state_e;

   state_e          state_q;
   logic [DT_W-1:0] cnt_q;
   logic            h_q, l_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         h_q     <= 1'b0;
         l_q     <= 1'b0;
      end else if (!en_i || fault_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         h_q     <= 1'b0;
         l_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= DEAD;
               cnt_q   <= dead_time_i;
            end
            HIGH: if (!pwm_i) begin
               state_q <= DEAD;
               cnt_q   <= dead_time_i;
               h_q     <= 1'b0;
            end
            LOW: if (pwm_i) begin
               state_q <= DEAD;
               cnt_q   <= dead_time_i;
               l_q     <= 1'b0;
            end
            DEAD: begin
               // A load of 0 still costs one DEAD cycle, so break-before-make holds.
               if (cnt_q <= DT_W'(1)) begin
                  state_q <= pwm_i ? HIGH : LOW;
                  cnt_q   <= '0;
                  h_q     <= pwm_i;
                  l_q     <= !pwm_i;
               end else begin
                  cnt_q <= cnt_q - DT_W'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               h_q     <= 1'b0;
               l_q     <= 1'b0;
            end
         endcase
      end
   end

   assign h_o = h_q;
   assign l_o = l_q;
endmodule

module pwm_deadtime_guard #(
   parameter int NCH         = 4,
   parameter int DT_W        = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic            wb_clk_i,
   input  logic            wb_rst_i,
   input  logic [NCH-1:0]  pwm_i,
   input  logic [NCH-1:0]  enable_i,
   input  logic [DT_W-1:0] dead_time_i,
   input  logic            pwm_fault_i,
   input  logic            fault_clr_i,
   output logic [NCH-1:0]  pwm_h_o,
   output logic [NCH-1:0]  pwm_l_o,
   output logic            fault_o,
   output logic            irq_o
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   fault_sync;
   logic                   fault_q, fault_d;

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) sync_q <= '0;
      else          sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_fault_i};
   end

   assign fault_sync = sync_q[SYNC_STAGES-1];

   // Set dominates clear when both land in the same cycle.
   always_comb begin
      fault_d = fault_q;
      if (fault_sync)       fault_d = 1'b1;
      else if (fault_clr_i) fault_d = 1'b0;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) fault_q <= 1'b0;
      else          fault_q <= fault_d;
   end

   assign fault_o = fault_q;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      pwm_deadtime_chan #(.DT_W(DT_W)) u_ch (
         .clk_i       (wb_clk_i),
         .rst_i       (wb_rst_i),
         .pwm_i       (pwm_i[g]),
         .en_i        (enable_i[g]),
         .dead_time_i (dead_time_i),
         .fault_i     (fault_q),
         .h_o         (pwm_h_o[g]),
         .l_o         (pwm_l_o[g])
      );
   end

`ifdef PWM_GUARD_IRQ_EN
   logic [7:0] fault_cnt_q, fault_cnt_d;

   always_comb begin
      fault_cnt_d = fault_cnt_q;
      if (fault_d && !fault_q && fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'd1;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) fault_cnt_q <= '0;
      else          fault_cnt_q <= fault_cnt_d;
   end

   assign irq_o = fault_q;
`else
   assign irq_o = 1'b0;
`endif
endmodule

// File: tb/tb_pwm_deadtime_guard.sv
// Directed bench for pwm_deadtime_guard: vector table plus dead-band, glitch, fault, reset and IRQ sequences.
module tb_pwm_deadtime_guard;
   localparam int NCH = 4, DT_W = 8, SYNC_STAGES = 2;
   localparam logic [NCH-1:0] ALL = '1;
`ifdef PWM_GUARD_IRQ_EN
   localparam logic IRQ_EN = 1'b1;
`else
   localparam logic IRQ_EN = 1'b0;
`endif

   logic            clk = 1'b0, rst = 1'b0;
   logic [NCH-1:0]  pwm = '0, en = '0;
   logic [DT_W-1:0] dt = '0;
   logic            flt = 1'b0, clr = 1'b0;
   logic [NCH-1:0]  h, l;
   logic            fo, irq;
   int              n_chk = 0, n_fail = 0;

   pwm_deadtime_guard #(.NCH(NCH), .DT_W(DT_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .pwm_i       (pwm),
      .enable_i    (en),
      .dead_time_i (dt),
      .pwm_fault_i (flt),
      .fault_clr_i (clr),
      .pwm_h_o     (h),
      .pwm_l_o     (l),
      .fault_o     (fo),
      .irq_o       (irq)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) begin
         n_chk++;
         if ((h & l) != '0) begin
            n_fail++;
            $display("FAIL overlap at %0t: h=%b l=%b", $time, h, l);
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic           p;
      logic [NCH-1:0] e;
      logic [DT_W-1:0] d;
      logic [NCH-1:0] eh;
      logic [NCH-1:0] el;
   } vec_t;
   vec_t tbl[19];

   initial begin
      tbl[0]  = '{1'b1, 4'b1011, 8'd2, 4'b0000, 4'b0000};
      tbl[1]  = '{1'b1, 4'b1011, 8'd2, 4'b0000, 4'b0000};
      tbl[2]  = '{1'b1, 4'b1011, 8'd2, 4'b1011, 4'b0000};
      tbl[3]  = '{1'b1, 4'b1011, 8'd2, 4'b1011, 4'b0000};
      tbl[4]  = '{1'b0, 4'b1011, 8'd2, 4'b0000, 4'b0000};
      tbl[5]  = '{1'b0, 4'b1011, 8'd2, 4'b0000, 4'b0000};
      tbl[6]  = '{1'b0, 4'b1011, 8'd2, 4'b0000, 4'b1011};
      tbl[7]  = '{1'b0, 4'b1011, 8'd2, 4'b0000, 4'b1011};
      tbl[8]  = '{1'b1, 4'b1011, 8'd0, 4'b0000, 4'b0000};
      tbl[9]  = '{1'b1, 4'b1011, 8'd0, 4'b1011, 4'b0000};
      tbl[10] = '{1'b0, 4'b1011, 8'd0, 4'b0000, 4'b0000};
      tbl[11] = '{1'b0, 4'b1011, 8'd0, 4'b0000, 4'b1011};
      tbl[12] = '{1'b0, 4'b0000, 8'd0, 4'b0000, 4'b0000};
      tbl[13] = '{1'b0, 4'b1111, 8'd1, 4'b0000, 4'b0000};
      tbl[14] = '{1'b0, 4'b1111, 8'd1, 4'b0000, 4'b1111};
      tbl[15] = '{1'b1, 4'b1111, 8'd3, 4'b0000, 4'b0000};
      tbl[16] = '{1'b1, 4'b1111, 8'd0, 4'b0000, 4'b0000};
      tbl[17] = '{1'b0, 4'b1111, 8'd0, 4'b0000, 4'b0000};
      tbl[18] = '{1'b1, 4'b1111, 8'd0, 4'b1111, 4'b0000};

      // Reset state, checked before any clock edge.
      #1 rst = 1'b1;
      #1;
      chk("reset h", h, 0);
      chk("reset l", l, 0);
      chk("reset fault", fo, 0);
      chk("reset irq", irq, 0);
      step();
      rst = 1'b0;
      step();

      for (int i = 0; i < 19; i++) begin
         pwm = tbl[i].p ? ALL : '0;
         en  = tbl[i].e;
         dt  = tbl[i].d;
         step();
         chk($sformatf("vec%0d h", i), h, tbl[i].eh);
         chk($sformatf("vec%0d l", i), l, tbl[i].el);
      end

      // 10 high / 10 low with dead_time 3: 3 both-low then 7 driven per half.
      dt = 8'd3; pwm = ALL; en = ALL;
      repeat (10) step();
      pwm = '0;
      for (int j = 0; j < 10; j++) begin
         step();
         chk($sformatf("t1 low%0d h", j), h, 0);
         chk($sformatf("t1 low%0d l", j), l, (j >= 3) ? ALL : '0);
      end
      pwm = ALL;
      for (int j = 0; j < 10; j++) begin
         step();
         chk($sformatf("t1 high%0d h", j), h, (j >= 3) ? ALL : '0);
         chk($sformatf("t1 high%0d l", j), l, 0);
      end

      // dead_time 0, toggle every 5 cycles: exactly one dead cycle per edge.
      dt = 8'd0;
      for (int w = 0; w < 4; w++) begin
         pwm = w[0] ? ALL : '0;
         for (int j = 0; j < 5; j++) begin
            step();
            chk($sformatf("t2 w%0d j%0d h", w, j), h, (w[0] && j >= 1) ? ALL : '0);
            chk($sformatf("t2 w%0d j%0d l", w, j), l, (!w[0] && j >= 1) ? ALL : '0);
         end
      end

      // 2-cycle low glitch inside a 6-cycle dead band: no low-side pulse.
      dt = 8'd6; pwm = ALL;
      repeat (3) step();
      for (int j = 0; j < 9; j++) begin
         pwm = (j < 2) ? '0 : ALL;
         step();
         chk($sformatf("t3 j%0d h", j), h, (j >= 6) ? ALL : '0);
         chk($sformatf("t3 j%0d l", j), l, 0);
      end

      // Fault: one-cycle pulse, latency, ignored clear, real clear, restart.
      dt = 8'd3;
      flt = 1'b1;
      step();
      flt = 1'b0;
      step();
      chk("t4 fault e2", fo, 0);
      chk("t4 h e2", h, ALL);
      step();
      chk("t4 fault e3", fo, 1);
      chk("t4 irq e3", irq, IRQ_EN);
      chk("t4 h e3", h, ALL);
      step();
      chk("t4 h off", h, 0);
      chk("t4 l off", l, 0);
      flt = 1'b1;
      repeat (3) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t4 clr ignored", fo, 1);
      flt = 1'b0;
      repeat (3) step();
      chk("t4 latched", fo, 1);
      chk("t4 h held off", h, 0);
      clr = 1'b1;
      step();
      clr = 1'b0;
      chk("t4 cleared", fo, 0);
      chk("t4 irq cleared", irq, 0);
      for (int j = 1; j <= 4; j++) begin
         step();
         chk($sformatf("t4 restart%0d h", j), h, (j == 4) ? ALL : '0);
         chk($sformatf("t4 restart%0d l", j), l, 0);
      end

      // Reset asserted between edges while driving: outputs drop immediately.
      #3 rst = 1'b1;
      #1;
      chk("t5 async h", h, 0);
      chk("t5 async l", l, 0);
      step();
      #2;
      rst = 1'b0; en = ALL; dt = 8'd4; pwm = ALL;
      for (int j = 1; j <= 5; j++) begin
         step();
         chk($sformatf("t5 rel%0d h", j), h, (j == 5) ? ALL : '0);
      end
      // Reset mid-DEAD, then restart toward the low side.
      pwm = '0;
      step();
      step();
      #3 rst = 1'b1;
      #1;
      chk("t5 dead rst h", h, 0);
      chk("t5 dead rst l", l, 0);
      chk("t5 dead rst fault", fo, 0);
      step();
      #2 rst = 1'b0;
      for (int j = 1; j <= 5; j++) begin
         step();
         chk($sformatf("t5b rel%0d l", j), l, (j == 5) ? ALL : '0);
         chk($sformatf("t5b rel%0d h", j), h, 0);
      end

      // Three separate fault/clear cycles for the IRQ path.
      for (int k = 0; k < 3; k++) begin
         flt = 1'b1;
         step();
         flt = 1'b0;
         repeat (3) step();
         chk($sformatf("t6 f%0d set", k), fo, 1);
         chk($sformatf("t6 f%0d irq", k), irq, IRQ_EN);
         clr = 1'b1;
         step();
         clr = 1'b0;
         chk($sformatf("t6 f%0d clr", k), fo, 0);
         chk($sformatf("t6 f%0d irq clr", k), irq, 0);
      end
`ifdef PWM_GUARD_IRQ_EN
      chk("t6 fault count", dut.fault_cnt_q, 3);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
